// File: rtl/web1_pkg.sv
// Shared definitions for the wake controller: FSM states and wake-cause encoding.
package web1_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ENTER = 2'd1,
    ST_SLEEP = 2'd2,
    ST_EXIT  = 2'd3
  } wake_state_e;

  localparam int CAUSE_W = 7;
  localparam logic [CAUSE_W-1:0] WAKE_CAUSE_NOW = 7'd127;

endpackage

// File: rtl/web1_wake_sync.sv
// Multi-stage flop synchronizer for a vector of asynchronous wake sources.
module web1_wake_sync #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stages [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stages[i] <= '0;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < STAGES; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = stages[STAGES-1];

endmodule

// File: rtl/web1_wake_ctrl.sv
// Low-power entry/exit controller: requests sleep from the power controller,
// watches synchronized wake sources while asleep and reports the wake cause.
module web1_wake_ctrl
  import web1_pkg::*;
#(
  parameter int N_WAKE      = 64,
  parameter int ACK_TIMEOUT = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_WAKE-1:0]  wake_in,
  input  logic [N_WAKE-1:0]  wake_enable_q,
  input  logic [N_WAKE-1:0]  input_invert_q,
  input  logic               activate_low_pwr_q,
  input  logic               event_suppress_q,
  input  logic               wake_now_q,
  input  logic               epu_enable_q,
  output logic               activate_low_pwr_d,
  output logic               activate_low_pwr_enb,
  output logic               wake_now_d,
  output logic               wake_now_enb,
  output logic               lp_req,
  input  logic               lp_ack,
  output logic               wake_irq,
  output logic [CAUSE_W-1:0] wake_cause,
  output logic               lp_err,
  output logic [1:0]         state_o
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  wake_state_e        state;
  logic [CNT_W-1:0]   ack_cnt;
  logic               no_irq;
  logic [N_WAKE-1:0]  wake_sync;
  logic [N_WAKE-1:0]  wake_vec;
  logic               wake_any;
  logic [CAUSE_W-1:0] first_idx;
  logic               lp_allowed;

  web1_wake_sync #(
    .WIDTH  (N_WAKE),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (wake_in),
    .q   (wake_sync)
  );

  assign wake_vec   = (wake_sync ^ input_invert_q) & wake_enable_q;
  assign lp_allowed = activate_low_pwr_q & epu_enable_q;

  // Lowest set index wins; scanning downward lets the last hit be the lowest.
  always_comb begin
    wake_any  = |wake_vec;
    first_idx = '0;
    for (int i = N_WAKE - 1; i >= 0; i--) begin
      if (wake_vec[i]) first_idx = CAUSE_W'(i);
    end
  end

  // Write-back enables are guarded by their own previous pulse because the
  // event register only reflects the clear one cycle after the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= ST_RUN;
      ack_cnt              <= '0;
      no_irq               <= 1'b0;
      lp_req               <= 1'b0;
      wake_irq             <= 1'b0;
      lp_err               <= 1'b0;
      wake_cause           <= '0;
      activate_low_pwr_enb <= 1'b0;
      wake_now_enb         <= 1'b0;
    end else begin
      wake_irq             <= 1'b0;
      lp_err               <= 1'b0;
      activate_low_pwr_enb <= 1'b0;
      wake_now_enb         <= 1'b0;
      case (state)
        ST_RUN: begin
          if (wake_now_q && !wake_now_enb) wake_now_enb <= 1'b1;
          if (lp_allowed && !activate_low_pwr_enb) begin
            state   <= ST_ENTER;
            lp_req  <= 1'b1;
            ack_cnt <= '0;
            no_irq  <= 1'b0;
          end
        end
        ST_ENTER: begin
          if (!lp_allowed) begin
            state  <= ST_EXIT;
            lp_req <= 1'b0;
            no_irq <= 1'b1;
          end else if (lp_ack) begin
            state <= ST_SLEEP;
          end else if (ack_cnt == CNT_LAST) begin
            state  <= ST_EXIT;
            lp_req <= 1'b0;
            lp_err <= 1'b1;
            no_irq <= 1'b1;
          end else begin
            ack_cnt <= ack_cnt + CNT_W'(1);
          end
        end
        ST_SLEEP: begin
          if (!lp_allowed) begin
            state  <= ST_EXIT;
            lp_req <= 1'b0;
            no_irq <= 1'b1;
          end else if (wake_now_q) begin
            state      <= ST_EXIT;
            lp_req     <= 1'b0;
            wake_cause <= WAKE_CAUSE_NOW;
          end else if (wake_any && !event_suppress_q) begin
            state      <= ST_EXIT;
            lp_req     <= 1'b0;
            wake_cause <= first_idx;
          end
        end
        ST_EXIT: begin
          if (!lp_ack) begin
            state                <= ST_RUN;
            wake_irq             <= !no_irq;
            activate_low_pwr_enb <= 1'b1;
            wake_now_enb         <= wake_now_q;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign activate_low_pwr_d = 1'b0;
  assign wake_now_d         = 1'b0;
  assign state_o            = state;

endmodule

// File: tb/tb_web1_wake_ctrl.sv
// Self-checking bench for web1_wake_ctrl: cycle model compared every cycle plus
// hand-computed directed expectations for latency, cause and timeout.
module tb_web1_wake_ctrl;

  localparam int NW = 64;
  localparam int TO = 20;
  localparam int SS = 2;

  logic          clk;
  logic          rst;
  logic [NW-1:0] wake_in, wake_enable_q, input_invert_q;
  logic          act_q, sup_q, wn_q, epu_q, lp_ack;
  logic          al_d, al_enb, wn_d, wn_enb, lp_req, wake_irq, lp_err;
  logic [6:0]    wake_cause;
  logic [1:0]    state_o;

  int checks   = 0;
  int failures = 0;
  int irq_seen = 0;
  bit cmp_en   = 0;

  web1_wake_ctrl #(
    .N_WAKE      (NW),
    .ACK_TIMEOUT (TO),
    .SYNC_STAGES (SS)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .wake_in              (wake_in),
    .wake_enable_q        (wake_enable_q),
    .input_invert_q       (input_invert_q),
    .activate_low_pwr_q   (act_q),
    .event_suppress_q     (sup_q),
    .wake_now_q           (wn_q),
    .epu_enable_q         (epu_q),
    .activate_low_pwr_d   (al_d),
    .activate_low_pwr_enb (al_enb),
    .wake_now_d           (wn_d),
    .wake_now_enb         (wn_enb),
    .lp_req               (lp_req),
    .lp_ack               (lp_ack),
    .wake_irq             (wake_irq),
    .wake_cause           (wake_cause),
    .lp_err               (lp_err),
    .state_o              (state_o)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: phase 0 run, 1 entering, 2 asleep, 3 leaving.
  int            m_phase, m_enter_cycles;
  int            m_cause;
  bit            m_silent, m_irq, m_err, m_al, m_wn;
  logic [NW-1:0] m_delay [SS];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_enter_cycles = 0; m_cause = 0; m_silent = 0;
      m_irq = 0; m_err = 0; m_al = 0; m_wn = 0;
      for (int i = 0; i < SS; i++) m_delay[i] = '0;
    end else begin
      automatic logic [NW-1:0] seen = (m_delay[SS-1] ^ input_invert_q) & wake_enable_q;
      automatic int lowest = -1;
      automatic bit n_irq = 0, n_err = 0, n_al = 0, n_wn = 0;
      for (int i = 0; i < NW; i++) if (seen[i] && lowest < 0) lowest = i;
      if (m_phase == 0) begin
        if (wn_q && !m_wn) n_wn = 1;
        if (act_q && epu_q && !m_al) begin m_phase = 1; m_enter_cycles = 0; m_silent = 0; end
      end else if (m_phase == 1 || m_phase == 2) begin
        if (!(act_q && epu_q)) begin m_phase = 3; m_silent = 1; end
        else if (m_phase == 1) begin
          if (lp_ack) m_phase = 2;
          else begin
            m_enter_cycles++;
            if (m_enter_cycles == TO) begin m_phase = 3; n_err = 1; m_silent = 1; end
          end
        end else if (wn_q) begin m_phase = 3; m_cause = 127; end
        else if (lowest >= 0 && !sup_q) begin m_phase = 3; m_cause = lowest; end
      end else if (!lp_ack) begin
        m_phase = 0; n_irq = !m_silent; n_al = 1; n_wn = wn_q;
      end
      for (int i = SS - 1; i > 0; i--) m_delay[i] = m_delay[i-1];
      m_delay[0] = wake_in;
      m_irq = n_irq; m_err = n_err; m_al = n_al; m_wn = n_wn;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      checkOutput("m_state",  32'(state_o),    32'(m_phase));
      checkOutput("m_lp_req", 32'(lp_req),     32'(m_phase == 1 || m_phase == 2));
      checkOutput("m_irq",    32'(wake_irq),   32'(m_irq));
      checkOutput("m_err",    32'(lp_err),     32'(m_err));
      checkOutput("m_al_enb", 32'(al_enb),     32'(m_al));
      checkOutput("m_wn_enb", 32'(wn_enb),     32'(m_wn));
      checkOutput("m_al_d",   32'(al_d),       32'd0);
      checkOutput("m_wn_d",   32'(wn_d),       32'd0);
      checkOutput("m_cause",  32'(wake_cause), 32'(m_cause));
      if (wake_irq) irq_seen++;
    end
  end

  // Steps cycles while emulating the event register accepting write-backs.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      if (al_enb && !al_d) act_q = 1'b0;
      if (wn_enb && !wn_d) wn_q = 1'b0;
    end
  endtask

  task automatic waitState(input logic [1:0] target, input int budget, input string name, output int cycles);
    cycles = 0;
    while (state_o !== target && cycles < budget) begin
      applyStimulus(1);
      cycles++;
    end
    checkOutput(name, 32'(state_o), 32'(target));
  endtask

  task automatic goSleep();
    int c;
    act_q = 1; epu_q = 1;
    waitState(2'd1, 4, "enter", c);
    lp_ack = 1;
    waitState(2'd2, 4, "sleep", c);
  endtask

  task automatic finishExit();
    lp_ack = 0;
    applyStimulus(1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    rst = 1; wake_in = '0; wake_enable_q = '0; input_invert_q = '0;
    act_q = 0; sup_q = 0; wn_q = 0; epu_q = 0; lp_ack = 0;
    #12;
    checkOutput("rst_state", 32'(state_o), 32'd0);
    checkOutput("rst_lp_req", 32'(lp_req), 32'd0);
    checkOutput("rst_cause", 32'(wake_cause), 32'd0);
    @(negedge clk); rst = 0; cmp_en = 1;

    // wake_now in RUN is just cleared
    wn_q = 1;
    applyStimulus(1);
    checkOutput("run_wn_enb", 32'(wn_enb), 32'd1);
    applyStimulus(1);
    checkOutput("run_wn_enb_once", 32'(wn_enb), 32'd0);
    checkOutput("run_wn_state", 32'(state_o), 32'd0);

    // wake source active in RUN has no effect
    wake_enable_q[5] = 1; wake_in[5] = 1;
    applyStimulus(4);
    checkOutput("run_ignores_wake", 32'(state_o), 32'd0);
    wake_in[5] = 0;
    applyStimulus(3);

    // single enabled source wakes after the sync delay
    goSleep();
    checkOutput("sleep_lp_req", 32'(lp_req), 32'd1);
    wake_in[5] = 1;
    waitState(2'd3, 10, "wake5_exit", c);
    checkOutput("wake5_latency", 32'(c), 32'(SS + 1));
    checkOutput("wake5_cause", 32'(wake_cause), 32'd5);
    checkOutput("exit_lp_req", 32'(lp_req), 32'd0);
    applyStimulus(2);
    checkOutput("exit_waits_ack", 32'(state_o), 32'd3);
    finishExit();
    checkOutput("wake5_irq", 32'(wake_irq), 32'd1);
    checkOutput("wake5_al_enb", 32'(al_enb), 32'd1);
    applyStimulus(1);
    checkOutput("wake5_irq_once", 32'(wake_irq), 32'd0);
    wake_in = '0;
    applyStimulus(3);

    // inverted source 40 reads active while the pin is low
    wake_enable_q = '0; wake_enable_q[40] = 1; input_invert_q[40] = 1;
    goSleep();
    waitState(2'd3, 6, "inv40_exit", c);
    checkOutput("inv40_cause", 32'(wake_cause), 32'd40);
    finishExit();
    input_invert_q = '0;
    applyStimulus(3);

    // simultaneous sources resolve to the lowest index
    wake_enable_q = '0; wake_enable_q[3] = 1; wake_enable_q[9] = 1;
    goSleep();
    wake_in[3] = 1; wake_in[9] = 1;
    waitState(2'd3, 10, "low_exit", c);
    checkOutput("low_cause", 32'(wake_cause), 32'd3);
    finishExit();
    wake_in = '0;
    applyStimulus(3);

    // wake_now beats simultaneous sources
    goSleep();
    wake_in[3] = 1; wake_in[9] = 1; wn_q = 1;
    waitState(2'd3, 6, "now_exit", c);
    checkOutput("now_cause", 32'(wake_cause), 32'd127);
    finishExit();
    checkOutput("now_wn_enb", 32'(wn_enb), 32'd1);
    checkOutput("now_irq", 32'(wake_irq), 32'd1);
    wake_in = '0;
    applyStimulus(3);

    // suppress holds sleep until released
    wake_enable_q = '0; wake_enable_q[5] = 1; sup_q = 1;
    goSleep();
    wake_in[5] = 1;
    applyStimulus(6);
    checkOutput("sup_hold", 32'(state_o), 32'd2);
    sup_q = 0;
    applyStimulus(1);
    checkOutput("sup_release", 32'(state_o), 32'd3);
    finishExit();
    wake_in = '0;
    applyStimulus(3);

    // ack timeout
    act_q = 1; epu_q = 1;
    waitState(2'd1, 4, "to_enter", c);
    c = 0;
    while (!lp_err && c < TO + 5) begin applyStimulus(1); c++; end
    checkOutput("to_err_cycle", 32'(c), 32'(TO));
    checkOutput("to_state", 32'(state_o), 32'd3);
    checkOutput("to_lp_req", 32'(lp_req), 32'd0);
    checkOutput("to_cause_kept", 32'(wake_cause), 32'd5);
    applyStimulus(1);
    checkOutput("to_no_irq", 32'(wake_irq), 32'd0);
    checkOutput("to_al_enb", 32'(al_enb), 32'd1);
    applyStimulus(3);

    // software abort from sleep
    goSleep();
    epu_q = 0;
    waitState(2'd3, 4, "abort_exit", c);
    checkOutput("abort_cause_kept", 32'(wake_cause), 32'd5);
    finishExit();
    checkOutput("abort_no_irq", 32'(wake_irq), 32'd0);
    applyStimulus(3);

    // asynchronous reset mid-sleep
    goSleep();
    #2 rst = 1;
    #1;
    checkOutput("arst_lp_req", 32'(lp_req), 32'd0);
    checkOutput("arst_state", 32'(state_o), 32'd0);
    act_q = 0; epu_q = 0; lp_ack = 0;
    @(negedge clk); rst = 0;
    applyStimulus(3);

    checkOutput("irq_total", 32'(irq_seen), 32'd5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
